stream_packetizer: RTL and testbench

Downstream stage of the header adder. Absorbs its valid-only 128-bit stream, which has no ready/backpressure, into an on-chip FIFO. Re-emits the stream as a full AXI4-Stream with `tready` honoured, `tlast` marking every packet boundary and `tkeep` trimming the final beat of each packet. Beats arriving while the FIFO is full are dropped and counted, so loss is visible to software.

---
 rtl/stream_packetizer_pkg.sv | 21 ++
 rtl/stream_packetizer_if.sv | 17 +
 rtl/stream_packetizer_fifo.sv | 54 +++++
 rtl/stream_packetizer.sv | 127 ++++++++++++
 tb/tb_stream_packetizer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_packetizer_pkg.sv
// Shared constants, beat-count helper and output state encoding for the stream packetizer.
package stream_packetizer_pkg;

    localparam int SP_DW      = 128;
    localparam int SP_BYTES   = SP_DW / 8;
    localparam int SP_KEEP_W  = SP_BYTES;
    localparam int BEAT_CNT_W = 17;

    typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } out_state_e;

    // 17 bits leave headroom for num + den - 1 with a 16-bit length.
    function automatic beat_cnt_t ceil_div(input beat_cnt_t num, input beat_cnt_t den);
        return (num + den - beat_cnt_t'(1)) / den;
    endfunction

endpackage

// File: rtl/stream_packetizer_if.sv
// Stream bundle used for both the valid-only input side and the AXI4-Stream output side.
interface stream_packetizer_if
    import stream_packetizer_pkg::*;
#(
    parameter int DW = SP_DW
) ();
    localparam int KW = DW / 8;

    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic [KW-1:0] tkeep;

    modport master (output tdata, tvalid, tlast, tkeep, input  tready);
    modport slave  (input  tdata, tvalid, tlast, tkeep, output tready);
endinterface

// File: rtl/stream_packetizer_fifo.sv
// axis_sync_fifo: single-clock FIFO with registered level; head word is readable without a pop.
module axis_sync_fifo #(
    parameter int DW    = 128,
    parameter int DEPTH = 64
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DW-1:0]             din,
    output logic [DW-1:0]             dout,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_push;
    logic          w_pop;

    // Flags come from the registered level, so a same-cycle pop never frees a slot.
    assign full   = (r_level == (AW + 1)'(DEPTH));
    assign empty  = (r_level == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign dout   = r_mem[r_rd_ptr];
    assign level  = r_level;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: rtl/stream_packetizer.sv
// Buffers a valid-only stream and re-emits it as AXI4-Stream with tlast/tkeep per packet.
// Optional macro STREAM_PACKETIZER_OVF_CNT_EN builds the saturating dropped-beat counter.
module stream_packetizer
    import stream_packetizer_pkg::*;
#(
    parameter int DW         = SP_DW,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [15:0]                  PACKET_SIZE,
    stream_packetizer_if.slave           axis_in,
    stream_packetizer_if.master          axis_out,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [31:0]                  overflow_count
);
    localparam int               BYTES    = DW / 8;
    localparam logic [BYTES-1:0] KEEP_ALL = '1;
    localparam beat_cnt_t        BYTES_C  = beat_cnt_t'(BYTES);

    out_state_e       r_state;
    out_state_e       w_state_next;
    logic [DW-1:0]    r_tdata;
    logic             r_tlast;
    logic [BYTES-1:0] r_tkeep;
    beat_cnt_t        r_beat_idx;
    logic [15:0]      r_pkt_len;

    logic [DW-1:0]    w_fifo_dout;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_load;
    logic [15:0]      w_len_sel;
    beat_cnt_t        w_len;
    beat_cnt_t        w_nbeats;
    beat_cnt_t        w_rem;
    logic             w_is_last;
    logic [BYTES-1:0] w_keep_last;
    logic             w_unused_in;

    // The input has no backpressure: beats that do not fit are dropped, never stalled.
    assign axis_in.tready = 1'b1;
    assign w_unused_in    = ^{axis_in.tlast, axis_in.tkeep};

    assign w_load = ~w_fifo_empty & ((r_state == ST_IDLE) | axis_out.tready);

    axis_sync_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (axis_in.tvalid),
        .pop    (w_load),
        .din    (axis_in.tdata),
        .dout   (w_fifo_dout),
        .level  (fifo_level),
        .full   (w_fifo_full),
        .empty  (w_fifo_empty)
    );

    // The first beat of a packet sees the live size; later beats use the captured one.
    assign w_len_sel = (r_beat_idx == '0) ? PACKET_SIZE : r_pkt_len;
    assign w_len     = (w_len_sel == 16'd0) ? BYTES_C : beat_cnt_t'(w_len_sel);
    assign w_nbeats  = ceil_div(w_len, BYTES_C);
    assign w_rem     = w_len - (w_nbeats - beat_cnt_t'(1)) * BYTES_C;
    assign w_is_last = (r_beat_idx == (w_nbeats - beat_cnt_t'(1)));

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_keep
        assign w_keep_last[gi] = (beat_cnt_t'(gi) < w_rem);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tdata    <= '0;
            r_tlast    <= 1'b0;
            r_tkeep    <= '0;
            r_beat_idx <= '0;
            r_pkt_len  <= '0;
        end else if (w_load) begin
            r_tdata    <= w_fifo_dout;
            r_tlast    <= w_is_last;
            r_tkeep    <= w_is_last ? w_keep_last : KEEP_ALL;
            r_beat_idx <= w_is_last ? '0 : r_beat_idx + beat_cnt_t'(1);
            if (r_beat_idx == '0) r_pkt_len <= PACKET_SIZE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_load) w_state_next = ST_VALID;
            ST_VALID: if (axis_out.tready && !w_load) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        axis_out.tvalid = (r_state == ST_VALID);
        axis_out.tdata  = r_tdata;
        axis_out.tlast  = r_tlast;
        axis_out.tkeep  = r_tkeep;
    end

`ifdef STREAM_PACKETIZER_OVF_CNT_EN
    logic [31:0] r_ovf_cnt;
    logic        w_drop;

    assign w_drop = axis_in.tvalid & w_fifo_full;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                         r_ovf_cnt <= '0;
        else if (w_drop && (r_ovf_cnt != '1)) r_ovf_cnt <= r_ovf_cnt + 32'd1;
    end

    assign overflow_count = r_ovf_cnt;
`else
    logic w_unused_full;
    assign w_unused_full  = w_fifo_full;
    assign overflow_count = '0;
`endif
endmodule

// File: tb/tb_stream_packetizer.sv
// Randomised and directed bench for stream_packetizer against a queue-based packet model.
module tb_stream_packetizer;
    import stream_packetizer_pkg::*;

    localparam int DW    = SP_DW;
    localparam int DEPTH = 64;
    localparam int B     = SP_BYTES;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [B-1:0]  keep;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   resetn = 1'b0;
    logic [15:0]            packet_size = 16'd64;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [31:0]            overflow_count;

    stream_packetizer_if #(.DW(DW)) in_if ();
    stream_packetizer_if #(.DW(DW)) out_if ();

    stream_packetizer #(.DW(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .PACKET_SIZE    (packet_size),
        .axis_in        (in_if),
        .axis_out       (out_if),
        .fifo_level     (fifo_level),
        .overflow_count (overflow_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int seq = 0;

    beat_t         log_q[$];
    logic [DW-1:0] fifo_q[$];
    bit            m_valid = 1'b0;
    beat_t         m_out;
    int            m_idx = 0;
    int            m_len = 0;
    longint        m_drops = 0;
    int            cnt, L, N, R;
    bit            hs, load;
    logic [31:0]   exp_ovf;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [B-1:0] keep_mask(input int r);
        logic [B-1:0] m;
        m = '0;
        for (int i = 0; i < r; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Model: FIFO of accepted beats plus one output slot, packet geometry from plain arithmetic.
    initial begin
        forever begin
            @(posedge clk);
            if (!resetn) begin
                fifo_q.delete();
                m_valid = 1'b0;
                m_idx   = 0;
                m_drops = 0;
            end else begin
                cnt  = fifo_q.size();
                hs   = m_valid && out_if.tready;
                load = (cnt > 0) && (!m_valid || out_if.tready);
                if (hs) log_q.push_back(m_out);
                if (load) begin
                    if (m_idx == 0) m_len = int'(packet_size);
                    L = (m_len == 0) ? B : m_len;
                    N = (L + B - 1) / B;
                    R = L - (N - 1) * B;
                    m_out.data = fifo_q.pop_front();
                    m_out.last = (m_idx == N - 1);
                    m_out.keep = m_out.last ? keep_mask(R) : '1;
                    m_idx      = m_out.last ? 0 : m_idx + 1;
                    m_valid    = 1'b1;
                end else if (hs) begin
                    m_valid = 1'b0;
                end
                if (in_if.tvalid) begin
                    if (cnt < DEPTH) fifo_q.push_back(in_if.tdata);
                    else if (m_drops < 64'hFFFF_FFFF) m_drops++;
                end
            end
            #1;
            if (resetn) begin
`ifdef STREAM_PACKETIZER_OVF_CNT_EN
                exp_ovf = m_drops[31:0];
`else
                exp_ovf = 32'd0;
`endif
                chk("tvalid", DW'(out_if.tvalid), DW'(m_valid));
                if (m_valid) begin
                    chk("tdata", out_if.tdata, m_out.data);
                    chk("tlast", DW'(out_if.tlast), DW'(m_out.last));
                    chk("tkeep", DW'(out_if.tkeep), DW'(m_out.keep));
                end
                chk("fifo_level", DW'(fifo_level), DW'(fifo_q.size()));
                chk("overflow_count", DW'(overflow_count), DW'(exp_ovf));
            end
        end
    end

    task automatic drive_beat();
        in_if.tvalid = 1'b1;
        in_if.tdata  = {$urandom, $urandom, $urandom, 32'(seq)};
        seq++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_if.tvalid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        #2 resetn = 1'b0;
        in_if.tvalid = 1'b0;
        #1;
        chk("rst_tvalid", DW'(out_if.tvalid), '0);
        chk("rst_tlast", DW'(out_if.tlast), '0);
        chk("rst_tkeep", DW'(out_if.tkeep), '0);
        chk("rst_tdata", out_if.tdata, '0);
        chk("rst_level", DW'(fifo_level), '0);
        chk("rst_ovf", DW'(overflow_count), '0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        log_q.delete();
    endtask

    // Literal expectations on delivered beats: order by sequence tag, tlast positions, last keep.
    task automatic check_pkts(input string tag, input int n, input int base,
                              input logic [127:0] last_vec, input logic [B-1:0] last_keep);
        chk($sformatf("%s_count", tag), DW'(log_q.size()), DW'(n));
        for (int i = 0; i < n && i < log_q.size(); i++) begin
            chk($sformatf("%s_seq%0d", tag, i), DW'(log_q[i].data[31:0]), DW'(base + i));
            chk($sformatf("%s_last%0d", tag, i), DW'(log_q[i].last), DW'(last_vec[i]));
            chk($sformatf("%s_keep%0d", tag, i), DW'(log_q[i].keep),
                DW'(last_vec[i] ? last_keep : {B{1'b1}}));
        end
        $display("scenario %s: %0d beats delivered", tag, log_q.size());
    endtask

    logic [15:0]  sizes [9] = '{16'd0, 16'd1, 16'd15, 16'd16, 16'd17, 16'd40, 16'd64, 16'd100, 16'd255};
    logic [127:0] vec;
    int           base;
    int           stall;

    initial begin
        in_if.tvalid  = 1'b0;
        in_if.tdata   = '0;
        in_if.tlast   = 1'b0;
        in_if.tkeep   = '1;
        out_if.tready = 1'b1;
        @(negedge clk);

        // Two 4-beat packets, plus first-beat latency.
        do_reset();
        packet_size = 16'd64;
        base = seq;
        drive_beat();
        chk("lat_edge_k_tvalid", DW'(out_if.tvalid), '0);
        chk("lat_edge_k_level", DW'(fifo_level), DW'(1));
        drive_beat();
        chk("lat_edge_k1_tvalid", DW'(out_if.tvalid), DW'(1));
        chk("lat_edge_k1_seq", DW'(out_if.tdata[31:0]), DW'(base));
        repeat (6) drive_beat();
        idle(6);
        check_pkts("ps64", 8, base, 128'h88, 16'hFFFF);

        // 40-byte packets: 3 beats, last keeps 8 bytes.
        do_reset();
        packet_size = 16'd40;
        base = seq;
        repeat (6) drive_beat();
        idle(6);
        check_pkts("ps40", 6, base, 128'h24, 16'h00FF);

        // Overflow with tready low, then drain in order.
        do_reset();
        packet_size   = 16'd64;
        out_if.tready = 1'b0;
        base = seq;
        repeat (70) drive_beat();
        idle(2);
        chk("ovf_level", DW'(fifo_level), DW'(64));
        chk("ovf_tvalid", DW'(out_if.tvalid), DW'(1));
`ifdef STREAM_PACKETIZER_OVF_CNT_EN
        chk("ovf_count", DW'(overflow_count), DW'(5));
`else
        chk("ovf_count", DW'(overflow_count), DW'(0));
`endif
        out_if.tready = 1'b1;
        idle(75);
        vec = '0;
        for (int i = 0; i < 65; i++) vec[i] = (i % 4 == 3);
        check_pkts("ovf_drain", 65, base, vec, 16'hFFFF);

        // Size change mid-packet only affects the next packet.
        do_reset();
        packet_size = 16'd64;
        base = seq;
        repeat (2) drive_beat();
        idle(4);
        packet_size = 16'd32;
        repeat (4) drive_beat();
        idle(6);
        check_pkts("ps_change", 6, base, 128'h28, 16'hFFFF);

        // Reset with 10 beats buffered; next beat restarts at beat 0.
        do_reset();
        packet_size   = 16'd64;
        out_if.tready = 1'b0;
        repeat (11) drive_beat();
        chk("mid_rst_level", DW'(fifo_level), DW'(10));
        do_reset();
        out_if.tready = 1'b1;
        packet_size   = 16'd32;
        base = seq;
        repeat (2) drive_beat();
        idle(5);
        check_pkts("after_rst", 2, base, 128'h2, 16'hFFFF);

        // Zero size: every beat is a full single-beat packet.
        do_reset();
        packet_size = 16'd0;
        base = seq;
        repeat (5) drive_beat();
        idle(5);
        check_pkts("ps0", 5, base, 128'h1F, 16'hFFFF);

        // Random traffic with bursty backpressure, checked cycle by cycle against the model.
        do_reset();
        stall = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) packet_size = sizes[$urandom_range(0, 8)];
            if ($urandom_range(0, 149) == 0) stall = $urandom_range(20, 90);
            if (stall > 0) begin
                out_if.tready = 1'b0;
                stall--;
            end else begin
                out_if.tready = ($urandom_range(0, 99) < 70);
            end
            in_if.tvalid = ($urandom_range(0, 99) < 75);
            in_if.tdata  = {$urandom, $urandom, $urandom, 32'(seq)};
            seq++;
            @(negedge clk);
        end
        out_if.tready = 1'b1;
        idle(80);
        chk("random_drained_level", DW'(fifo_level), '0);
        $display("scenario random: %0d beats delivered", log_q.size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
